// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU command driver.
// Op encoding, command bundle and driver FSM states.
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } drv_state_e;

    // op is kept raw so illegal codes survive to the error check
    typedef struct packed {
        logic [2:0]       op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic             use_acc;
    } alu_cmd_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= ALU_XOR;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: command queue for alu_cmd_driver.
// Wrap-bit pointers distinguish full from empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t wdata,
    input  logic     pop,
    output alu_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    alu_cmd_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready front end for the combinational ALU.
// Define ALU_CMD_DRIVER_STATS_EN to build the stat_ops/stat_carry counters.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_use_acc,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_y,
    input  logic         alu_zero,
    input  logic         alu_carry,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_y,
    output logic         rsp_zero,
    output logic         rsp_carry,
    output logic         rsp_err,
    output logic [W-1:0] acc,
    output logic [15:0]  stat_ops,
    output logic [15:0]  stat_carry
);

    drv_state_e state_q;
    drv_state_e state_d;
    alu_cmd_t   cmd_in;
    alu_cmd_t   head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       cap;

    always_comb begin
        cmd_in         = '0;
        cmd_in.op      = cmd_op;
        cmd_in.a       = cmd_a;
        cmd_in.b       = cmd_b;
        cmd_in.use_acc = cmd_use_acc;
    end

    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign rsp_valid = (state_q == RESP);

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cap     = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // acc is written at capture, always before the next pop reads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_y     <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            acc       <= '0;
        end else begin
            if (pop) begin
                alu_a  <= head.use_acc ? acc : head.a;
                alu_b  <= head.b;
                alu_op <= head.op;
            end
            if (cap) begin
                if (is_legal_op(alu_op)) begin
                    rsp_y     <= alu_y;
                    rsp_zero  <= alu_zero;
                    rsp_carry <= alu_carry;
                    rsp_err   <= 1'b0;
                    acc       <= alu_y;
                end else begin
                    rsp_y     <= '0;
                    rsp_zero  <= 1'b1;
                    rsp_carry <= 1'b0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_CMD_DRIVER_STATS_EN
    logic [15:0] ops_q;
    logic [15:0] carry_q;
    logic        hs;

    assign hs = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q   <= '0;
            carry_q <= '0;
        end else if (hs) begin
            if (ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
            if (rsp_carry && carry_q != 16'hFFFF)
                carry_q <= carry_q + 16'd1;
        end
    end

    assign stat_ops   = ops_q;
    assign stat_carry = carry_q;
`else
    assign stat_ops   = '0;
    assign stat_carry = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed bench with a behavioural ALU and
// an in-order response scoreboard for alu_cmd_driver.
module tb_alu_cmd_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [3:0]  cmd_a = '0;
    logic [3:0]  cmd_b = '0;
    logic        cmd_use_acc = 1'b0;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_y;
    logic        alu_zero;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_y;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_err;
    logic [3:0]  acc;
    logic [15:0] stat_ops;
    logic [15:0] stat_carry;

    int checks = 0;
    int failures = 0;
    int rsp_count = 0;

    typedef struct {
        logic [3:0] y;
        logic       zero;
        logic       carry;
        logic       err;
        logic [3:0] acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] model_acc = '0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.W(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_y       (alu_y),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_zero    (rsp_zero),
        .rsp_carry   (rsp_carry),
        .rsp_err     (rsp_err),
        .acc         (acc),
        .stat_ops    (stat_ops),
        .stat_carry  (stat_carry)
    );

    // Stand-in for the team ALU
    always_comb begin
        alu_y     = '0;
        alu_carry = 1'b0;
        case (alu_op)
            3'd0: {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: begin
                alu_y     = alu_a - alu_b;
                alu_carry = alu_a < alu_b;
            end
            3'd2: alu_y = alu_a & alu_b;
            3'd3: alu_y = alu_a | alu_b;
            3'd4: alu_y = alu_a ^ alu_b;
            default: alu_y = 4'h5;
        endcase
        alu_zero = (alu_y == 4'h0);
    end

    function automatic exp_t predict(input logic [2:0] op,
                                     input logic [3:0] a,
                                     input logic [3:0] b,
                                     input logic [3:0] acc_in);
        exp_t e;
        int   av;
        int   bv;
        int   r;
        av = int'(a);
        bv = int'(b);
        e.err = 1'b0;
        e.carry = 1'b0;
        e.y = '0;
        case (op)
            3'd0: begin
                r = av + bv;
                e.y = 4'(r % 16);
                e.carry = (r > 15);
            end
            3'd1: begin
                r = av - bv;
                e.y = 4'((r + 16) % 16);
                e.carry = (r < 0);
            end
            3'd2: e.y = a & b;
            3'd3: e.y = a | b;
            3'd4: e.y = a ^ b;
            default: e.err = 1'b1;
        endcase
        e.zero = (e.y == 4'h0);
        e.acc = e.err ? acc_in : e.y;
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every valid response, then log accepts
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_spurious actual=%h expected=none",
                             rsp_y);
                end else begin
                    chk("rsp_model",
                        {5'd0, rsp_y, rsp_zero, rsp_carry, rsp_err, acc},
                        {5'd0, exp_q[0].y, exp_q[0].zero, exp_q[0].carry,
                         exp_q[0].err, exp_q[0].acc});
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        rsp_count++;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_t e;
                e = predict(cmd_op, cmd_use_acc ? model_acc : cmd_a,
                            cmd_b, model_acc);
                model_acc = e.acc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic ua);
        logic ok;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_use_acc = ua;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        chk("send_accept", {15'd0, ok}, 16'd1);
    endtask

    task automatic wait_rsp(input string name, input logic [3:0] y,
                            input logic z, input logic c, input logic e,
                            input logic [3:0] ax);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_seen"}, {15'd0, got}, 16'd1);
        if (got)
            chk(name, {5'd0, rsp_y, rsp_zero, rsp_carry, rsp_err, acc},
                {5'd0, y, z, c, e, ax});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        chk("rst_acc", {12'd0, acc}, 16'd0);
        chk("rst_alu_regs", {5'd0, alu_a, alu_b, alu_op}, 16'd0);
        chk("rst_rsp_regs",
            {9'd0, rsp_y, rsp_zero, rsp_carry, rsp_err}, 16'd0);
        sync();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", {15'd0, rsp_valid}, 16'd0);
        end

        // latency and add with carry out
        rsp_ready = 1'b1;
        sync();
        send(3'd0, 4'd9, 4'd8, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_n0", {15'd0, rsp_valid}, 16'd0);
        @(negedge clk);
        chk("lat_n1", {15'd0, rsp_valid}, 16'd0);
        @(negedge clk);
        chk("lat_n2", {15'd0, rsp_valid}, 16'd1);
        chk("add_9_8", {5'd0, rsp_y, rsp_zero, rsp_carry, rsp_err, acc},
            {5'd0, 4'h1, 1'b0, 1'b1, 1'b0, 4'h1});

        // subtract: zero result, then borrow
        sync();
        send(3'd1, 4'd3, 4'd3, 1'b0);
        cmd_valid = 1'b0;
        wait_rsp("sub_3_3", 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        sync();
        send(3'd1, 4'd2, 4'd3, 1'b0);
        cmd_valid = 1'b0;
        wait_rsp("sub_2_3", 4'hF, 1'b0, 1'b1, 1'b0, 4'hF);

        // backpressure: fill FIFO behind a stalled response
        sync();
        base = rsp_count;
        rsp_ready = 1'b0;
        send(3'd0, 4'h7, 4'h7, 1'b0);
        send(3'd1, 4'h1, 4'h4, 1'b0);
        send(3'd2, 4'hC, 4'hA, 1'b0);
        send(3'd3, 4'h5, 4'h2, 1'b0);
        send(3'd4, 4'hF, 4'hF, 1'b0);
        fork
            send(3'd0, 4'hF, 4'h1, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_cmd_ready", {15'd0, cmd_ready}, 16'd0);
                    chk("stall_hold_y", {12'd0, rsp_y}, 16'hE);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) break;
        end
        chk("drain_count", 16'(rsp_count - base), 16'd6);
        chk("drain_acc", {12'd0, acc}, 16'h0);

        // accumulator chaining and illegal op
        sync();
        send(3'd0, 4'h5, 4'h0, 1'b0);
        cmd_valid = 1'b0;
        wait_rsp("chain_load", 4'h5, 1'b0, 1'b0, 1'b0, 4'h5);
        sync();
        send(3'd0, 4'hA, 4'h7, 1'b1);
        cmd_valid = 1'b0;
        wait_rsp("chain_add", 4'hC, 1'b0, 1'b0, 1'b0, 4'hC);
        sync();
        send(3'd4, 4'h3, 4'hC, 1'b1);
        cmd_valid = 1'b0;
        wait_rsp("chain_xor", 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        sync();
        send(3'b110, 4'h3, 4'h4, 1'b0);
        cmd_valid = 1'b0;
        wait_rsp("illegal_op", 4'h0, 1'b1, 1'b0, 1'b1, 4'h0);

        // reset while in DRIVE with two commands queued
        sync();
        rsp_ready = 1'b0;
        send(3'd0, 4'h1, 4'h1, 1'b0);
        send(3'd0, 4'h2, 4'h2, 1'b0);
        send(3'd0, 4'h3, 4'h3, 1'b0);
        send(3'd0, 4'h4, 4'h4, 1'b0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        sync();
        chk("pre_rst_acc", {12'd0, acc}, 16'h2);
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        model_acc = '0;
        #1;
        chk("midrst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        chk("midrst_acc", {12'd0, acc}, 16'd0);
        chk("midrst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("midrst_alu_regs", {5'd0, alu_a, alu_b, alu_op}, 16'd0);
        sync();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_midrst_quiet", {15'd0, rsp_valid}, 16'd0);
        end
        chk("post_midrst_ready", {15'd0, cmd_ready}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
